// File: rtl/dmem_controller_if.sv
// MA-stage data-memory port: request/size/data from the CPU, load data and status back.
interface dmem_controller_if;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic        load_unsigned;
    logic [31:0] data_out;
    logic        busy;
    logic        misaligned;

    modport master (
        output address, data_in, mem_read, mem_write, load_unsigned,
        input  data_out, busy, misaligned
    );

    modport slave (
        input  address, data_in, mem_read, mem_write, load_unsigned,
        output data_out, busy, misaligned
    );
endinterface

// File: rtl/dmem_controller.sv
// Data-memory responder: fixed-latency stall, byte/half/word loads and stores on a
// word-organised array, misaligned requests flagged and suppressed.
module dmem_controller #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_controller_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state, next_state;
    logic [CNT_W-1:0]      cnt;
    logic [31:0]           mem [DEPTH];

    logic                  req, live_write;
    logic [1:0]            live_size;

    logic [ADDR_WIDTH+1:0] lat_addr;
    logic [31:0]           lat_data;
    logic [1:0]            lat_size;
    logic                  lat_write, lat_unsigned;

    logic [ADDR_WIDTH+1:0] eff_addr;
    logic [ADDR_WIDTH-1:0] eff_idx;
    logic [31:0]           eff_data;
    logic [1:0]            eff_size;
    logic                  eff_write, eff_unsigned, eff_aligned;
    logic                  commit;

    logic [31:0]           rd_word, load_val, wr_word;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [3:0]            wr_be;
    logic [31:0]           dout_q;
    logic                  mis_q;

    logic                  unused_addr_hi;
    assign unused_addr_hi = ^bus.address[31:ADDR_WIDTH+2];

    always_comb begin
        req        = (bus.mem_read != 2'b00) || (bus.mem_write != 2'b00);
        live_write = (bus.mem_write != 2'b00);
        live_size  = live_write ? bus.mem_write : bus.mem_read;
    end

    // With LATENCY=1 the commit edge is also the accept edge, so IDLE uses the live inputs.
    always_comb begin
        if (state == IDLE) begin
            eff_addr     = bus.address[ADDR_WIDTH+1:0];
            eff_data     = bus.data_in;
            eff_size     = live_size;
            eff_write    = live_write;
            eff_unsigned = bus.load_unsigned;
        end else begin
            eff_addr     = lat_addr;
            eff_data     = lat_data;
            eff_size     = lat_size;
            eff_write    = lat_write;
            eff_unsigned = lat_unsigned;
        end
        eff_idx = eff_addr[ADDR_WIDTH+1:2];
        case (eff_size)
            2'b10:   eff_aligned = ~eff_addr[0];
            2'b11:   eff_aligned = (eff_addr[1:0] == 2'b00);
            default: eff_aligned = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE:    if (req) cnt <= CNT_W'(LATENCY - 1);
                ACCESS:  cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = (LATENCY == 1) ? DONE : ACCESS;
            ACCESS:  if (cnt == CNT_W'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        commit = (state != DONE) && (next_state == DONE);
    end

    // Output logic
    always_comb begin
        bus.busy       = reset && (((state == IDLE) && req) || (state == ACCESS));
        bus.data_out   = dout_q;
        bus.misaligned = mis_q;
    end

    always_comb begin
        rd_word   = mem[eff_idx];
        lane_byte = 8'(rd_word >> {eff_addr[1:0], 3'b000});
        lane_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (eff_size)
            2'b01:   load_val = {{24{~eff_unsigned & lane_byte[7]}}, lane_byte};
            2'b10:   load_val = {{16{~eff_unsigned & lane_half[15]}}, lane_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        case (eff_size)
            2'b01: begin
                wr_word = {4{eff_data[7:0]}};
                wr_be   = 4'b0001 << eff_addr[1:0];
            end
            2'b10: begin
                wr_word = {2{eff_data[15:0]}};
                wr_be   = eff_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_word = eff_data;
                wr_be   = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_addr     <= '0;
            lat_data     <= '0;
            lat_size     <= '0;
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            dout_q       <= '0;
            mis_q        <= 1'b0;
        end else begin
            if ((state == IDLE) && req) begin
                lat_addr     <= bus.address[ADDR_WIDTH+1:0];
                lat_data     <= bus.data_in;
                lat_size     <= live_size;
                lat_write    <= live_write;
                lat_unsigned <= bus.load_unsigned;
            end
            // Any edge other than the commit edge clears the fault flag.
            mis_q <= commit && !eff_aligned;
            if (commit && !eff_write)
                dout_q <= eff_aligned ? load_val : '0;
        end
    end

    // Array has no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && commit && eff_aligned && eff_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[eff_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end
endmodule
